// File: rtl/tl_pkg.sv
// Shared phase encoding, lamp codes and default phase lengths for the traffic light monitor.
package tl_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_UNSYNC = 2'b11
    } phase_e;

    // Lamp order on the light bus is {Red, Yellow, Green}
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam int unsigned DEF_RED_LEN    = 5;
    localparam int unsigned DEF_GREEN_LEN  = 7;
    localparam int unsigned DEF_YELLOW_LEN = 3;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned CYC_W = 8;

    // True only for the normal R->G, G->Y, Y->R progression
    function automatic logic is_legal_step(input logic [1:0] from_ph, input logic [1:0] to_ph);
        return ((from_ph == PH_RED)    && (to_ph == PH_GREEN))  ||
               ((from_ph == PH_GREEN)  && (to_ph == PH_YELLOW)) ||
               ((from_ph == PH_YELLOW) && (to_ph == PH_RED));
    endfunction

endpackage

// File: rtl/tl_light_decode.sv
// Combinational decode of the one-hot lamp bus into {valid, phase}.
module tl_light_decode
    import tl_pkg::*;
(
    input  logic [2:0] light,
    output logic       valid_c,
    output logic [1:0] phase_c
);

    always_comb begin
        valid_c = 1'b1;
        phase_c = PH_UNSYNC;
        case (light)
            LAMP_RED:    phase_c = PH_RED;
            LAMP_GREEN:  phase_c = PH_GREEN;
            LAMP_YELLOW: phase_c = PH_YELLOW;
            default:     valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Tracks an observed R-G-Y light sequence, flagging illegal codes, bad order and bad phase lengths.
// Phase length checking is built only when TLMON_TIMING_CHECK_EN is defined.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned RED_LEN    = DEF_RED_LEN,
    parameter int unsigned GREEN_LEN  = DEF_GREEN_LEN,
    parameter int unsigned YELLOW_LEN = DEF_YELLOW_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] phase_cnt,
    output logic             err_illegal,
    output logic             err_seq,
    output logic             err_time,
    output logic             cycle_done,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic             err_sticky
);

    localparam logic [1:0]       S_RED    = PH_RED;
    localparam logic [1:0]       S_GREEN  = PH_GREEN;
    localparam logic [1:0]       S_YELLOW = PH_YELLOW;
    localparam logic [1:0]       S_UNSYNC = PH_UNSYNC;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CYC_W-1:0] CYC_MAX  = '1;

    if (RED_LEN < 1 || RED_LEN > 15) begin : g_bad_red_len
        $error("RED_LEN must be within 1..15");
    end
    if (GREEN_LEN < 1 || GREEN_LEN > 15) begin : g_bad_green_len
        $error("GREEN_LEN must be within 1..15");
    end
    if (YELLOW_LEN < 1 || YELLOW_LEN > 15) begin : g_bad_yellow_len
        $error("YELLOW_LEN must be within 1..15");
    end

    logic             dec_valid;
    logic [1:0]       dec_phase;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             rg_ok_q, rg_ok_d;
    logic             gy_ok_q, gy_ok_d;
    logic             ill_q, ill_d;
    logic             seq_q, seq_d;
    logic             done_q, done_d;
    logic             sticky_q, sticky_d;
    logic             time_d;
    logic             legal_step;

`ifdef TLMON_TIMING_CHECK_EN
    logic             chk_q, chk_d;
    logic             ovr_q, ovr_d;
    logic             time_q;
    logic [CNT_W-1:0] cur_len;

    // Required length of the phase currently being tracked
    always_comb begin
        case (state_q)
            S_RED:   cur_len = CNT_W'(RED_LEN);
            S_GREEN: cur_len = CNT_W'(GREEN_LEN);
            default: cur_len = CNT_W'(YELLOW_LEN);
        endcase
    end
`endif

    tl_light_decode u_decode (
        .light   (light),
        .valid_c (dec_valid),
        .phase_c (dec_phase)
    );

    // Next-state and pulse generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        rg_ok_d     = rg_ok_q;
        gy_ok_d     = gy_ok_q;
        ill_d       = 1'b0;
        seq_d       = 1'b0;
        done_d      = 1'b0;
        time_d      = 1'b0;
        legal_step  = is_legal_step(state_q, dec_phase);
`ifdef TLMON_TIMING_CHECK_EN
        chk_d       = chk_q;
        ovr_d       = ovr_q;
`endif

        if (!dec_valid) begin
            ill_d   = 1'b1;
            state_d = S_UNSYNC;
            cnt_d   = '0;
            rg_ok_d = 1'b0;
            gy_ok_d = 1'b0;
`ifdef TLMON_TIMING_CHECK_EN
            chk_d   = 1'b0;
            ovr_d   = 1'b0;
`endif
        end else if (state_q == S_UNSYNC) begin
            state_d = dec_phase;
            cnt_d   = CNT_W'(1);
            rg_ok_d = 1'b0;
            gy_ok_d = 1'b0;
`ifdef TLMON_TIMING_CHECK_EN
            chk_d   = 1'b0;
            ovr_d   = 1'b0;
`endif
        end else if (dec_phase == state_q) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef TLMON_TIMING_CHECK_EN
            // Overrun reported once, on the sample that pushes past the length
            if (chk_q && !ovr_q && (cnt_q == cur_len)) begin
                time_d = 1'b1;
                ovr_d  = 1'b1;
            end
`endif
        end else begin
            state_d = dec_phase;
            cnt_d   = CNT_W'(1);
            if (!legal_step) begin
                seq_d   = 1'b1;
                rg_ok_d = 1'b0;
                gy_ok_d = 1'b0;
`ifdef TLMON_TIMING_CHECK_EN
                chk_d   = 1'b0;
                ovr_d   = 1'b0;
`endif
            end else begin
`ifdef TLMON_TIMING_CHECK_EN
                time_d = chk_q && !ovr_q && (cnt_q < cur_len);
                chk_d  = 1'b1;
                ovr_d  = 1'b0;
`endif
                case (state_q)
                    S_RED:   rg_ok_d = 1'b1;
                    S_GREEN: gy_ok_d = 1'b1;
                    default: begin
                        done_d  = rg_ok_q && gy_ok_q;
                        rg_ok_d = 1'b0;
                        gy_ok_d = 1'b0;
                    end
                endcase
            end
        end

        // A timing error breaks the cycle currently being assembled
        if (time_d) begin
            rg_ok_d = 1'b0;
            gy_ok_d = 1'b0;
            done_d  = 1'b0;
        end

        if (done_d && (cycle_cnt_q != CYC_MAX)) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end

        sticky_d = (sticky_q && !clr_err) || ill_d || seq_d || time_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_UNSYNC;
            cnt_q       <= '0;
            cycle_cnt_q <= '0;
            rg_ok_q     <= 1'b0;
            gy_ok_q     <= 1'b0;
            ill_q       <= 1'b0;
            seq_q       <= 1'b0;
            done_q      <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            rg_ok_q     <= rg_ok_d;
            gy_ok_q     <= gy_ok_d;
            ill_q       <= ill_d;
            seq_q       <= seq_d;
            done_q      <= done_d;
            sticky_q    <= sticky_d;
        end
    end

`ifdef TLMON_TIMING_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q  <= 1'b0;
            ovr_q  <= 1'b0;
            time_q <= 1'b0;
        end else begin
            chk_q  <= chk_d;
            ovr_q  <= ovr_d;
            time_q <= time_d;
        end
    end

    assign err_time = time_q;
`else
    assign err_time = 1'b0;
`endif

    assign phase       = state_q;
    assign phase_cnt   = cnt_q;
    assign err_illegal = ill_q;
    assign err_seq     = seq_q;
    assign cycle_done  = done_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (defaults R=5, G=7, Y=3).
module tb_traffic_light_monitor;

`ifdef TLMON_TIMING_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic       clk;
    logic       rst;
    logic [2:0] light;
    logic       clr_err;
    logic [1:0] phase;
    logic [3:0] phase_cnt;
    logic       err_illegal;
    logic       err_seq;
    logic       err_time;
    logic       cycle_done;
    logic [7:0] cycle_cnt;
    logic       err_sticky;

    int n_chk;
    int n_fail;
    int n_ill, n_seq, n_time, n_done;

    traffic_light_monitor #(
        .RED_LEN    (5),
        .GREEN_LEN  (7),
        .YELLOW_LEN (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light       (light),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_cnt   (phase_cnt),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_time    (err_time),
        .cycle_done  (cycle_done),
        .cycle_cnt   (cycle_cnt),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [2:0] l);
        light = l;
        @(posedge clk);
        #1;
        if (err_illegal) n_ill++;
        if (err_seq) n_seq++;
        if (err_time) n_time++;
        if (cycle_done) n_done++;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        for (int i = 0; i < n; i++) step(l);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_err = 1'b0;
        light = LR;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_ill = 0; n_seq = 0; n_time = 0; n_done = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr_err = 1'b0;
        hold(LR, 3);
        hold(3'b111, 1);
        do_reset();
        n_chk++; if (phase !== 2'b11) begin n_fail++; $display("FAIL reset_phase: got %b want 11", phase); end
        n_chk++; if (phase_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_phase_cnt: got %0d want 0", phase_cnt); end
        n_chk++; if (cycle_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); end
        n_chk++; if ({err_sticky, err_illegal, err_seq, err_time, cycle_done} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {err_sticky, err_illegal, err_seq, err_time, cycle_done});
        end
    endtask

    task automatic test_full_cycle();
        do_reset();
        hold(LR, 5);
        n_chk++; if ({phase, phase_cnt} !== {2'b00, 4'd5}) begin n_fail++; $display("FAIL cyc_red: got %b/%0d want 00/5", phase, phase_cnt); end
        hold(LG, 7);
        n_chk++; if ({phase, phase_cnt} !== {2'b01, 4'd7}) begin n_fail++; $display("FAIL cyc_green: got %b/%0d want 01/7", phase, phase_cnt); end
        hold(LY, 3);
        n_chk++; if ({phase, phase_cnt} !== {2'b10, 4'd3}) begin n_fail++; $display("FAIL cyc_yellow: got %b/%0d want 10/3", phase, phase_cnt); end
        n_chk++; if (n_done !== 0) begin n_fail++; $display("FAIL cyc_early_done: got %0d want 0", n_done); end
        step(LR);
        n_chk++; if (cycle_done !== 1'b1) begin n_fail++; $display("FAIL cyc_done_pulse: got %b want 1", cycle_done); end
        n_chk++; if (cycle_cnt !== 8'd1) begin n_fail++; $display("FAIL cyc_cnt: got %0d want 1", cycle_cnt); end
        n_chk++; if ({phase, phase_cnt} !== {2'b00, 4'd1}) begin n_fail++; $display("FAIL cyc_red_reload: got %b/%0d want 00/1", phase, phase_cnt); end
        n_chk++; if (n_ill + n_seq + n_time !== 0) begin n_fail++; $display("FAIL cyc_no_err: got %0d want 0", n_ill + n_seq + n_time); end
        n_chk++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL cyc_sticky: got %b want 0", err_sticky); end
        step(LR);
        n_chk++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL cyc_done_width: got %b want 0", cycle_done); end
    endtask

    task automatic test_underrun();
        do_reset();
        hold(LR, 5); hold(LG, 7); hold(LY, 3); hold(LR, 5);
        hold(LG, 6);
        n_chk++; if (n_time !== 0) begin n_fail++; $display("FAIL under_pre: got %0d want 0", n_time); end
        step(LY);
        n_chk++; if (err_time !== TCHK) begin n_fail++; $display("FAIL under_pulse: got %b want %b", err_time, TCHK); end
        n_chk++; if (err_sticky !== TCHK) begin n_fail++; $display("FAIL under_sticky: got %b want %b", err_sticky, TCHK); end
        hold(LY, 3);
        n_chk++; if (n_time !== int'(TCHK)) begin n_fail++; $display("FAIL under_count: got %0d want %0d", n_time, TCHK); end
        n_chk++; if (cycle_cnt !== 8'd1) begin n_fail++; $display("FAIL under_cycle_cnt: got %0d want 1", cycle_cnt); end
    endtask

    task automatic test_overrun();
        do_reset();
        hold(LR, 5);
        for (int i = 1; i <= 9; i++) begin
            step(LG);
            n_chk++; if (err_time !== ((i == 8) ? TCHK : 1'b0)) begin
                n_fail++; $display("FAIL over_g%0d: got %b want %b", i, err_time, (i == 8) ? TCHK : 1'b0);
            end
        end
        n_chk++; if (phase_cnt !== 4'd9) begin n_fail++; $display("FAIL over_cnt: got %0d want 9", phase_cnt); end
        step(LY);
        n_chk++; if (err_time !== 1'b0) begin n_fail++; $display("FAIL over_gy: got %b want 0", err_time); end
        n_chk++; if (n_time !== int'(TCHK)) begin n_fail++; $display("FAIL over_count: got %0d want %0d", n_time, TCHK); end
    endtask

    task automatic test_sequence();
        do_reset();
        hold(LR, 3);
        step(LY);
        n_chk++; if (err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_pulse: got %b want 1", err_seq); end
        n_chk++; if ({phase, phase_cnt} !== {2'b10, 4'd1}) begin n_fail++; $display("FAIL seq_phase: got %b/%0d want 10/1", phase, phase_cnt); end
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %b want 1", err_sticky); end
        step(LY);
        step(LR);
        n_chk++; if ({cycle_done, err_time, err_seq} !== 3'b000) begin
            n_fail++; $display("FAIL seq_yr: got %b want 000", {cycle_done, err_time, err_seq});
        end
        n_chk++; if (phase !== 2'b00) begin n_fail++; $display("FAIL seq_yr_phase: got %b want 00", phase); end
        n_chk++; if (n_seq !== 1) begin n_fail++; $display("FAIL seq_count: got %0d want 1", n_seq); end
    endtask

    task automatic test_illegal();
        do_reset();
        hold(LR, 2);
        step(3'b110);
        n_chk++; if ({err_illegal, phase, phase_cnt} !== {1'b1, 2'b11, 4'd0}) begin
            n_fail++; $display("FAIL ill_first: got %b/%b/%0d want 1/11/0", err_illegal, phase, phase_cnt);
        end
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b want 1", err_sticky); end
        step(3'b000);
        n_chk++; if ({err_illegal, err_seq, err_time, cycle_done} !== 4'b1000) begin
            n_fail++; $display("FAIL ill_repeat: got %b want 1000", {err_illegal, err_seq, err_time, cycle_done});
        end
        clr_err = 1'b1;
        step(LG);
        n_chk++; if ({err_sticky, err_illegal, phase, phase_cnt} !== {1'b0, 1'b0, 2'b01, 4'd1}) begin
            n_fail++; $display("FAIL ill_clear_resync: got %b/%b/%b/%0d want 0/0/01/1", err_sticky, err_illegal, phase, phase_cnt);
        end
        step(3'b110);
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_set_clr: got %b want 1", err_sticky); end
        clr_err = 1'b0;
        step(LR);
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL ill_hold: got %b want 1", err_sticky); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        hold(LR, 5); hold(LG, 3);
        rst = 1'b1;
        step(LG);
        rst = 1'b0;
        n_chk++; if ({phase, phase_cnt} !== {2'b11, 4'd0}) begin n_fail++; $display("FAIL mid_rst: got %b/%0d want 11/0", phase, phase_cnt); end
        n_time = 0;
        hold(LG, 10);
        step(LY);
        n_chk++; if ({phase, n_time} !== {2'b10, 32'd0}) begin n_fail++; $display("FAIL mid_unchecked: got %b/%0d want 10/0", phase, n_time); end
    endtask

    task automatic test_saturation();
        do_reset();
        hold(LR, 20);
        n_chk++; if (phase_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_phase_cnt: got %0d want 15", phase_cnt); end
        n_chk++; if (n_time !== 0) begin n_fail++; $display("FAIL sat_entry_time: got %0d want 0", n_time); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hold(LR, 5); hold(LG, 7); hold(LY, 3);
        hold(LR, 5); hold(LG, 7); hold(LY, 3);
        step(LR);
        n_chk++; if ({cycle_cnt, n_done} !== {8'd2, 32'd2}) begin n_fail++; $display("FAIL b2b_cycles: got %0d/%0d want 2/2", cycle_cnt, n_done); end
        n_chk++; if (n_ill + n_seq + n_time !== 0) begin n_fail++; $display("FAIL b2b_no_err: got %0d want 0", n_ill + n_seq + n_time); end
    endtask

    task automatic test_cycle_saturation();
        do_reset();
        for (int c = 0; c < 256; c++) begin
            hold(LR, 5); hold(LG, 7); hold(LY, 3);
        end
        step(LR);
        n_chk++; if (n_done !== 256) begin n_fail++; $display("FAIL csat_done: got %0d want 256", n_done); end
        n_chk++; if (cycle_cnt !== 8'd255) begin n_fail++; $display("FAIL csat_cnt: got %0d want 255", cycle_cnt); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        n_ill = 0; n_seq = 0; n_time = 0; n_done = 0;
        rst = 1'b1; clr_err = 1'b0; light = 3'b000;
        @(posedge clk);
        #1;
        test_reset();
        test_full_cycle();
        test_underrun();
        test_overrun();
        test_sequence();
        test_illegal();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        test_cycle_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter RED_LEN, default 5: required Red phase length in clock cycles, legal range 1..15.
REQ-002 SHALL have parameter GREEN_LEN, default 7: required Green phase length in cycles, legal range 1..15.
REQ-003 SHALL have parameter YELLOW_LEN, default 3: required Yellow phase length in cycles, legal range 1..15.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk is the input clock, rst is the synchronous active-high reset input.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- light  in  3  observed lamps {Red,Yellow,Green}
- clr_err  in  1  clears err_sticky
- phase  out  2  tracked phase: 00 red, 01 green, 10 yellow, 11 unsynced
- phase_cnt  out  4  cycles spent in current phase, saturating
- err_illegal  out  1  pulse: encoding not 100/010/001
- err_seq  out  1  pulse: illegal phase order
- err_time  out  1  pulse: phase length wrong
- cycle_done  out  1  pulse: full R-G-Y cycle completed
- cycle_cnt  out  8  completed cycles, saturating
- err_sticky  out  1  any error since last clear

Function
REQ-006 All outputs SHALL be registered; light sampled at edge N is reflected on outputs after edge N (1-cycle latency).
REQ-007 FSM states SHALL be UNSYNC, RED, GREEN, YELLOW; phase output equals the state code.
REQ-008 UNSYNC SHALL move to the state matching the first legal light code; timing is not checked for that entry phase.
REQ-009 Same legal code as current state SHALL increment phase_cnt, saturating at 15.
REQ-010 Legal transitions R->G, G->Y, Y->R SHALL load phase_cnt with 1 and compare the old phase_cnt with the old phase's *_LEN.
REQ-011 Any other change between legal codes SHALL pulse err_seq, move to the new code's state, load phase_cnt with 1, and mark the new phase unchecked.
REQ-012 An illegal code SHALL pulse err_illegal every sampled cycle, force UNSYNC and clear phase_cnt; other pulses stay 0.
REQ-013 Overrun: when phase_cnt would exceed *_LEN in a checked phase, err_time SHALL pulse once; the subsequent transition SHALL NOT pulse it again.
REQ-014 Underrun: a legal transition with old phase_cnt < *_LEN in a checked phase SHALL pulse err_time.
REQ-015 cycle_done SHALL pulse on a Y->R transition only if R->G and G->Y were both legal since the last sync or error.
REQ-016 cycle_done SHALL increment cycle_cnt, saturating at 255.
REQ-017 err_sticky SHALL set on any error pulse and clear on clr_err; a simultaneous set and clear leaves it 1.

Reset
REQ-018 rst SHALL force state UNSYNC, phase=11, phase_cnt=0, cycle_cnt=0, err_sticky=0 and all pulses to 0.
REQ-019 rst asserted mid-phase SHALL discard all history; the next phase entered is unchecked.

Configuration
REQ-020 Macro TLMON_TIMING_CHECK_EN defined: REQ-013/014 are active.
REQ-021 Macro TLMON_TIMING_CHECK_EN undefined: err_time is tied 0, no length comparators are built, and phase_cnt still counts.

Structure
REQ-022 Package tl_pkg SHALL hold the phase enum (RED/GREEN/YELLOW/UNSYNC), the lamp codes 100/010/001 and the default lengths.
REQ-023 One combinational sub-module tl_light_decode SHALL map light to {valid, phase}.

Verification
REQ-024 Reset, then R x5, G x7, Y x3, R: exactly one cycle_done, cycle_cnt=1, no error pulses.
REQ-025 After a full cycle, G x6 then Y: err_time pulses once after the first Y edge, and err_sticky=1.
REQ-026 G held 9 cycles: err_time pulses once after the 8th G sample, and there is no pulse at the G->Y transition.
REQ-027 R->Y directly: err_seq pulses and phase=10; the following Y->R gives no cycle_done and no err_time.
REQ-028 light=110: err_illegal pulses and phase=11; clr_err in the same cycle as a new error leaves err_sticky=1.
REQ-029 TLMON_TIMING_CHECK_EN undefined, stimulus of REQ-025: err_time stays 0 and err_sticky stays 0.
